// File: rtl/stream_incr_stage_if.sv
// Valid/ready stream bundle for stream_incr_stage: upstream word in, incremented word and carry flag out.
interface stream_incr_stage_if #(
    parameter int WIDTH = 10
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_data;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;
    logic             o_wrap;

    modport slave (
        input  i_valid, i_data, i_ready,
        output o_ready, o_valid, o_data, o_wrap
    );

    modport master (
        output i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_data, o_wrap
    );
endinterface

// File: rtl/stream_incr_stage.sv
// Back-pressurable stage adding STEP to each stream word, with a carry flag per word and a
// saturating count of carry events. Two-entry skid buffer: a head register and a skid register.
module stream_incr_stage #(
    parameter int WIDTH     = 10,
    parameter int STEP      = 1,
    parameter int SATURATE  = 0,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    stream_incr_stage_if.slave   st,
    output logic [CNT_WIDTH-1:0] o_wrap_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Returns {wrap, data}; saturating mode clamps to all-ones on carry.
    function automatic logic [WIDTH:0] incr_word(input logic [WIDTH-1:0] d);
        logic [WIDTH:0] sum;
        sum = {1'b0, d} + (WIDTH+1)'(STEP);
        if (SATURATE != 0 && sum[WIDTH]) begin
            return {1'b1, {WIDTH{1'b1}}};
        end
        return sum;
    endfunction

    logic [WIDTH:0]   res_p0;
    logic             acc_p0;
    logic             pop_p1;
    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;
    logic             wrap_p1;
    logic             vld_p2;
    logic [WIDTH-1:0] data_p2;
    logic             wrap_p2;

    assign res_p0 = incr_word(st.i_data);
    assign acc_p0 = st.i_valid && st.o_ready;
    assign pop_p1 = vld_p1 && st.i_ready;

    assign st.o_ready = !vld_p2;
    assign st.o_valid = vld_p1;
    assign st.o_data  = data_p1;
    assign st.o_wrap  = wrap_p1;

    // Stage p0 -> p1/p2: head register feeds the output, skid register catches the second word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            wrap_p1 <= 1'b0;
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            wrap_p2 <= 1'b0;
        end else if (acc_p0 && !pop_p1) begin
            if (!vld_p1) begin
                vld_p1  <= 1'b1;
                data_p1 <= res_p0[WIDTH-1:0];
                wrap_p1 <= res_p0[WIDTH];
            end else begin
                vld_p2  <= 1'b1;
                data_p2 <= res_p0[WIDTH-1:0];
                wrap_p2 <= res_p0[WIDTH];
            end
        end else if (!acc_p0 && pop_p1) begin
            if (vld_p2) begin
                vld_p2  <= 1'b0;
                data_p1 <= data_p2;
                wrap_p1 <= wrap_p2;
            end else begin
                vld_p1  <= 1'b0;
            end
        end else if (acc_p0 && pop_p1) begin
            // Accept is only possible with the skid empty, so the new word goes straight to the head.
            data_p1 <= res_p0[WIDTH-1:0];
            wrap_p1 <= res_p0[WIDTH];
        end
    end

    // Carry events are counted as they are accepted; clear takes priority over a same-cycle event.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_wrap_count <= '0;
        end else if (i_clear) begin
            o_wrap_count <= '0;
        end else if (acc_p0 && res_p0[WIDTH] && o_wrap_count != CNT_MAX) begin
            o_wrap_count <= o_wrap_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_stream_incr_stage.sv
// Directed and random checks of stream_incr_stage across wrap, saturate, wide and small-counter builds.
module tb_stream_incr_stage;

    localparam int N = 10000;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // index 0: wrap W10, 1: saturate W10, 2: wrap W20, 3: wrap W10 with 2-bit counter
    logic        vin[4];
    logic        rin[4];
    logic [19:0] din[4];
    logic        ov[4];
    logic        ordy[4];
    logic        owr[4];
    logic [19:0] od[4];
    logic [7:0]  cnt[4];

    logic [7:0] cnt_a, cnt_s, cnt_w;
    logic [1:0] cnt_c;

    stream_incr_stage_if #(.WIDTH(10)) ifa ();
    stream_incr_stage_if #(.WIDTH(10)) ifs ();
    stream_incr_stage_if #(.WIDTH(20)) ifw ();
    stream_incr_stage_if #(.WIDTH(10)) ifc ();

    stream_incr_stage #(.WIDTH(10), .STEP(1), .SATURATE(0), .CNT_WIDTH(8)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_clear(clr), .st(ifa), .o_wrap_count(cnt_a));
    stream_incr_stage #(.WIDTH(10), .STEP(1), .SATURATE(1), .CNT_WIDTH(8)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_clear(clr), .st(ifs), .o_wrap_count(cnt_s));
    stream_incr_stage #(.WIDTH(20), .STEP(1), .SATURATE(0), .CNT_WIDTH(8)) dut_w (
        .i_clk(clk), .i_rst(rst), .i_clear(clr), .st(ifw), .o_wrap_count(cnt_w));
    stream_incr_stage #(.WIDTH(10), .STEP(1), .SATURATE(0), .CNT_WIDTH(2)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_clear(clr), .st(ifc), .o_wrap_count(cnt_c));

    assign ifa.i_valid = vin[0];
    assign ifa.i_ready = rin[0];
    assign ifa.i_data  = din[0][9:0];
    assign ifs.i_valid = vin[1];
    assign ifs.i_ready = rin[1];
    assign ifs.i_data  = din[1][9:0];
    assign ifw.i_valid = vin[2];
    assign ifw.i_ready = rin[2];
    assign ifw.i_data  = din[2];
    assign ifc.i_valid = vin[3];
    assign ifc.i_ready = rin[3];
    assign ifc.i_data  = din[3][9:0];

    assign ov[0] = ifa.o_valid;  assign ordy[0] = ifa.o_ready;
    assign od[0] = {10'd0, ifa.o_data};  assign owr[0] = ifa.o_wrap;
    assign ov[1] = ifs.o_valid;  assign ordy[1] = ifs.o_ready;
    assign od[1] = {10'd0, ifs.o_data};  assign owr[1] = ifs.o_wrap;
    assign ov[2] = ifw.o_valid;  assign ordy[2] = ifw.o_ready;
    assign od[2] = ifw.o_data;           assign owr[2] = ifw.o_wrap;
    assign ov[3] = ifc.o_valid;  assign ordy[3] = ifc.o_ready;
    assign od[3] = {10'd0, ifc.o_data};  assign owr[3] = ifc.o_wrap;
    assign cnt[0] = cnt_a;
    assign cnt[1] = cnt_s;
    assign cnt[2] = cnt_w;
    assign cnt[3] = {6'd0, cnt_c};

    logic [10:0] expq[2][16384];

    function automatic logic [10:0] ref_incr(input logic [9:0] d, input bit sat);
        if (d == 10'd1023) return sat ? 11'h7FF : 11'h400;
        return {1'b0, d + 10'd1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vin[k] = 1'b0;
            rin[k] = 1'b0;
            din[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (ov[0] !== 1'b0 || ordy[0] !== 1'b1 || od[0] !== 20'd0 || owr[0] !== 1'b0 || cnt[0] !== 8'd0) begin
            bad++;
            $display("FAIL reset_idle: got v=%0d r=%0d d=%0d w=%0d c=%0d want v=0 r=1 d=0 w=0 c=0",
                     ov[0], ordy[0], od[0], owr[0], cnt[0]);
        end
        vin[0] = 1'b1;
        din[0] = 20'd1023;
        tick();
        din[0] = 20'd5;
        tick();
        vin[0] = 1'b0;
        total++;
        if (ordy[0] !== 1'b0 || cnt[0] !== 8'd1) begin
            bad++;
            $display("FAIL reset_prefill: got r=%0d c=%0d want r=0 c=1", ordy[0], cnt[0]);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (ov[0] !== 1'b0 || ordy[0] !== 1'b1 || od[0] !== 20'd0 || owr[0] !== 1'b0 || cnt[0] !== 8'd0) begin
            bad++;
            $display("FAIL reset_async: got v=%0d r=%0d d=%0d w=%0d c=%0d want v=0 r=1 d=0 w=0 c=0",
                     ov[0], ordy[0], od[0], owr[0], cnt[0]);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        rin[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (ov[0] !== 1'b0) begin
                bad++;
                $display("FAIL reset_discard: cycle %0d got v=%0d want v=0", i, ov[0]);
            end
        end
    endtask

    task automatic test_latency();
        do_reset();
        rin[0] = 1'b1;
        vin[0] = 1'b1;
        din[0] = 20'd5;
        tick();
        total++;
        if (ov[0] !== 1'b1 || od[0] !== 20'd6 || owr[0] !== 1'b0) begin
            bad++;
            $display("FAIL latency_one: got v=%0d d=%0d w=%0d want v=1 d=6 w=0", ov[0], od[0], owr[0]);
        end
        for (int i = 0; i < 100; i++) begin
            din[0] = 20'(i);
            tick();
            total++;
            if (ov[0] !== 1'b1 || ordy[0] !== 1'b1 || od[0] !== 20'(i + 1)) begin
                bad++;
                $display("FAIL stream_word: in=%0d got v=%0d r=%0d d=%0d want v=1 r=1 d=%0d",
                         i, ov[0], ordy[0], od[0], i + 1);
            end
        end
        vin[0] = 1'b0;
        tick();
        total++;
        if (ov[0] !== 1'b0) begin
            bad++;
            $display("FAIL stream_drain: got v=%0d want v=0", ov[0]);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            vin[k] = 1'b1;
            rin[k] = 1'b1;
        end
        din[0] = 20'd1023;
        din[1] = 20'd1023;
        din[2] = 20'hFFFFF;
        tick();
        vin[0] = 1'b0;
        vin[2] = 1'b0;
        din[1] = 20'd1022;
        total++;
        if (od[0] !== 20'd0 || owr[0] !== 1'b1 || cnt[0] !== 8'd1) begin
            bad++;
            $display("FAIL wrap_mod: got d=%0d w=%0d c=%0d want d=0 w=1 c=1", od[0], owr[0], cnt[0]);
        end
        total++;
        if (od[1] !== 20'd1023 || owr[1] !== 1'b1 || cnt[1] !== 8'd1) begin
            bad++;
            $display("FAIL wrap_sat: got d=%0d w=%0d c=%0d want d=1023 w=1 c=1", od[1], owr[1], cnt[1]);
        end
        total++;
        if (od[2] !== 20'd0 || owr[2] !== 1'b1 || ov[2] !== 1'b1) begin
            bad++;
            $display("FAIL wrap_w20: got v=%0d d=%0d w=%0d want v=1 d=0 w=1", ov[2], od[2], owr[2]);
        end
        tick();
        vin[1] = 1'b0;
        total++;
        if (od[1] !== 20'd1023 || owr[1] !== 1'b0 || cnt[1] !== 8'd1) begin
            bad++;
            $display("FAIL sat_nowrap: got d=%0d w=%0d c=%0d want d=1023 w=0 c=1", od[1], owr[1], cnt[1]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        vin[0] = 1'b1;
        din[0] = 20'd10;
        tick();
        total++;
        if (ordy[0] !== 1'b1 || ov[0] !== 1'b1 || od[0] !== 20'd11) begin
            bad++;
            $display("FAIL skid_first: got r=%0d v=%0d d=%0d want r=1 v=1 d=11", ordy[0], ov[0], od[0]);
        end
        din[0] = 20'd11;
        tick();
        total++;
        if (ordy[0] !== 1'b0 || od[0] !== 20'd11) begin
            bad++;
            $display("FAIL skid_full: got r=%0d d=%0d want r=0 d=11", ordy[0], od[0]);
        end
        din[0] = 20'd12;
        tick();
        total++;
        if (ordy[0] !== 1'b0 || ov[0] !== 1'b1 || od[0] !== 20'd11) begin
            bad++;
            $display("FAIL skid_hold: got r=%0d v=%0d d=%0d want r=0 v=1 d=11", ordy[0], ov[0], od[0]);
        end
        rin[0] = 1'b1;
        tick();
        total++;
        if (ordy[0] !== 1'b1 || ov[0] !== 1'b1 || od[0] !== 20'd12) begin
            bad++;
            $display("FAIL skid_second: got r=%0d v=%0d d=%0d want r=1 v=1 d=12", ordy[0], ov[0], od[0]);
        end
        tick();
        vin[0] = 1'b0;
        total++;
        if (ov[0] !== 1'b1 || od[0] !== 20'd13) begin
            bad++;
            $display("FAIL skid_third: got v=%0d d=%0d want v=1 d=13", ov[0], od[0]);
        end
        tick();
        total++;
        if (ov[0] !== 1'b0) begin
            bad++;
            $display("FAIL skid_empty: got v=%0d want v=0", ov[0]);
        end
    endtask

    task automatic test_counter();
        do_reset();
        rin[3] = 1'b1;
        vin[3] = 1'b1;
        din[3] = 20'd1023;
        for (int i = 1; i <= 5; i++) begin
            tick();
            total++;
            if (cnt[3] !== 8'((i < 3) ? i : 3) || od[3] !== 20'd0 || owr[3] !== 1'b1) begin
                bad++;
                $display("FAIL cnt_sat: word %0d got c=%0d d=%0d w=%0d want c=%0d d=0 w=1",
                         i, cnt[3], od[3], owr[3], (i < 3) ? i : 3);
            end
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++;
        if (cnt[3] !== 8'd0 || ov[3] !== 1'b1 || od[3] !== 20'd0) begin
            bad++;
            $display("FAIL cnt_clear: got c=%0d v=%0d d=%0d want c=0 v=1 d=0", cnt[3], ov[3], od[3]);
        end
        tick();
        vin[3] = 1'b0;
        total++;
        if (cnt[3] !== 8'd1) begin
            bad++;
            $display("FAIL cnt_after_clear: got c=%0d want c=1", cnt[3]);
        end
        tick();
    endtask

    task automatic test_soak();
        int          sent[2];
        int          got[2];
        int          refc[2];
        int          wr[2];
        int          rd[2];
        logic        accd[2];
        logic        popd[2];
        logic        stall[2];
        logic [19:0] held[2];
        logic        heldw[2];
        logic [10:0] e;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            sent[k] = 0; got[k] = 0; refc[k] = 0; wr[k] = 0; rd[k] = 0;
            accd[k] = 1'b0; stall[k] = 1'b0; held[k] = '0; heldw[k] = 1'b0;
        end
        for (int cyc = 0; cyc < 40000 && (got[0] < N || got[1] < N); cyc++) begin
            for (int k = 0; k < 2; k++) begin
                if (stall[k]) begin
                    total++;
                    if (ov[k] !== 1'b1 || od[k] !== held[k] || owr[k] !== heldw[k]) begin
                        bad++;
                        $display("FAIL soak_stall%0d: got v=%0d d=%0d w=%0d want v=1 d=%0d w=%0d",
                                 k, ov[k], od[k], owr[k], held[k], heldw[k]);
                    end
                end
                total++;
                if (cnt[k] !== 8'(refc[k])) begin
                    bad++;
                    $display("FAIL soak_count%0d: got %0d want %0d", k, cnt[k], refc[k]);
                end
                if (!(vin[k] && !accd[k])) begin
                    vin[k] = (sent[k] < N) && ($urandom_range(3) != 0);
                    din[k] = ($urandom_range(3) == 0) ? 20'd1023 : 20'($urandom_range(1023));
                end
                rin[k]  = ($urandom_range(3) != 0);
                accd[k] = vin[k] && ordy[k];
                popd[k] = ov[k] && rin[k];
                if (popd[k]) begin
                    total++;
                    if (rd[k] >= wr[k]) begin
                        bad++;
                        $display("FAIL soak_extra%0d: got d=%0d want no word", k, od[k]);
                    end else if ({owr[k], od[k][9:0]} !== expq[k][rd[k]]) begin
                        bad++;
                        $display("FAIL soak_data%0d: word %0d got w=%0d d=%0d want w=%0d d=%0d", k, rd[k],
                                 owr[k], od[k][9:0], expq[k][rd[k]][10], expq[k][rd[k]][9:0]);
                    end
                    rd[k]++;
                    got[k]++;
                end
                if (accd[k]) begin
                    e = ref_incr(din[k][9:0], k == 1);
                    expq[k][wr[k]] = e;
                    wr[k]++;
                    sent[k]++;
                    if (e[10] && refc[k] < 255) refc[k]++;
                end
                stall[k] = ov[k] && !rin[k];
                held[k]  = od[k];
                heldw[k] = owr[k];
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            vin[k] = 1'b0;
            total++;
            if (got[k] != N || cnt[k] !== 8'(refc[k])) begin
                bad++;
                $display("FAIL soak_end%0d: got words=%0d c=%0d want words=%0d c=%0d",
                         k, got[k], cnt[k], N, refc[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_wrap();
        test_back_to_back();
        test_counter();
        test_soak();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
